// File: rtl/bfc_pkg.sv
// rtl/bfc_pkg.sv - phase type, kick-back constants and per-key LED bounds for bound_flash_checker
package bfc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    RESYNC = 2'd3
  } phase_t;

  localparam int          MAX_KEY  = 3;
  localparam logic [1:0]  LAST_KEY = 2'(MAX_KEY - 1);
  localparam logic [15:0] KICK_LO  = 16'h0000;
  localparam logic [15:0] KICK_HI  = 16'h001F;

  // Element i holds the bound for key i.
  localparam logic [MAX_KEY-1:0][15:0] KEY_MAX = {16'h003F, 16'h07FF, 16'hFFFF};
  localparam logic [MAX_KEY-1:0][15:0] KEY_MIN = {16'h0000, 16'h0000, 16'h001F};

  function automatic logic [15:0] key_max(input logic [1:0] key);
    return (key < 2'(MAX_KEY)) ? KEY_MAX[key] : 16'hFFFF;
  endfunction

  function automatic logic [15:0] key_min(input logic [1:0] key);
    return (key < 2'(MAX_KEY)) ? KEY_MIN[key] : 16'h0000;
  endfunction

endpackage

// File: rtl/bfc_next_led.sv
// rtl/bfc_next_led.sv - combinational next-state of the ideal flasher model (phase, key, expected LED)
module bfc_next_led
  import bfc_pkg::*;
(
  input  phase_t      phase,
  input  logic [1:0]  key,
  input  logic [15:0] exp_led,
  input  logic        flick,
  output phase_t      nxt_phase,
  output logic [1:0]  nxt_key,
  output logic [15:0] nxt_led
);

  logic kick;
  assign kick = flick && (key != LAST_KEY) && (exp_led == KICK_LO || exp_led == KICK_HI);

  always_comb begin
    nxt_phase = phase;
    nxt_key   = key;
    nxt_led   = exp_led;
    unique case (phase)
      IDLE: begin
        nxt_led = '0;
        if (flick) nxt_phase = UP;
      end
      UP: begin
        if (exp_led != key_max(key)) begin
          nxt_led = {exp_led[14:0], 1'b1};
        end else begin
          nxt_led   = {1'b0, exp_led[15:1]};
          nxt_phase = DOWN;
        end
      end
      DOWN: begin
        // A trigger at a kick-back point restarts the climb and wins over the key advance.
        if (kick) begin
          nxt_phase = UP;
        end else if (exp_led != key_min(key)) begin
          nxt_led = {1'b0, exp_led[15:1]};
        end else if (key != LAST_KEY) begin
          nxt_key   = key + 2'd1;
          nxt_led   = {exp_led[14:0], 1'b1};
          nxt_phase = UP;
        end else begin
          nxt_key   = '0;
          nxt_led   = '0;
          nxt_phase = IDLE;
        end
      end
      RESYNC: begin
        nxt_led = '0;
      end
      default: begin
        nxt_phase = IDLE;
        nxt_key   = '0;
        nxt_led   = '0;
      end
    endcase
  end

endmodule

// File: rtl/bound_flash_checker.sv
// rtl/bound_flash_checker.sv - compares a sampled LED flasher against its ideal model
// BFC_ERR_CNT_EN builds the saturating mismatch counter; otherwise ERR_CNT is tied to zero.
module bound_flash_checker
  import bfc_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLICK,
  input  logic [15:0] LED,
  output logic [15:0] EXP_LED,
  output logic [1:0]  PHASE,
  output logic        MISMATCH,
  output logic        ERR,
  output logic        SEQ_DONE,
  output logic [7:0]  ERR_CNT
);

  phase_t      phase, nxt_phase;
  logic [1:0]  key, nxt_key;
  logic [15:0] exp_led, nxt_led;
  logic        bad;

  bfc_next_led u_next (
    .phase     (phase),
    .key       (key),
    .exp_led   (exp_led),
    .flick     (FLICK),
    .nxt_phase (nxt_phase),
    .nxt_key   (nxt_key),
    .nxt_led   (nxt_led)
  );

  assign bad = (phase != RESYNC) && (LED != exp_led);

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase    <= IDLE;
      key      <= '0;
      exp_led  <= '0;
      MISMATCH <= 1'b0;
      ERR      <= 1'b0;
      SEQ_DONE <= 1'b0;
    end else begin
      MISMATCH <= bad;
      SEQ_DONE <= 1'b0;
      if (bad) begin
        phase   <= RESYNC;
        key     <= '0;
        exp_led <= '0;
        ERR     <= 1'b1;
      end else if (phase == RESYNC) begin
        exp_led <= '0;
        if (LED == 16'h0000) phase <= IDLE;
      end else begin
        phase    <= nxt_phase;
        key      <= nxt_key;
        exp_led  <= nxt_led;
        // The only DOWN->IDLE transition is the end of the last key.
        SEQ_DONE <= (phase == DOWN) && (nxt_phase == IDLE);
      end
    end
  end

`ifdef BFC_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (bad && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign ERR_CNT = err_cnt;
`else
  assign ERR_CNT = 8'h00;
`endif

  assign EXP_LED = exp_led;
  assign PHASE   = phase;

endmodule

// File: tb/tb_bound_flash_checker.sv
// tb/tb_bound_flash_checker.sv - randomized self-checking bench against an ideal LED sequence model
module tb_bound_flash_checker;

  localparam logic [1:0] P_IDLE = 2'd0, P_UP = 2'd1, P_DOWN = 2'd2, P_RESYNC = 2'd3;

  logic        CLK, RST, FLICK;
  logic [15:0] LED, EXP_LED;
  logic [1:0]  PHASE;
  logic        MISMATCH, ERR, SEQ_DONE;
  logic [7:0]  ERR_CNT;

  bound_flash_checker dut (
    .CLK(CLK), .RST(RST), .FLICK(FLICK), .LED(LED), .EXP_LED(EXP_LED), .PHASE(PHASE),
    .MISMATCH(MISMATCH), .ERR(ERR), .SEQ_DONE(SEQ_DONE), .ERR_CNT(ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] led;
    logic [1:0]  ph;
    int          key;
    bit          flick;
    bit          kick_ok;
    bit          done;
  } ent_t;

  ent_t seq[$];
  int   maxw[3] = '{16, 11, 6};
  int   minw[3] = '{5, 0, 0};
  int   total = 0;
  int   bad = 0;
  bit   err_m = 0;
  int   cnt_m = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ones(input int n);
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [7:0] cnt_exp();
`ifdef BFC_ERR_CNT_EN
    return 8'(cnt_m);
`else
    return 8'h00;
`endif
  endfunction

  task automatic push(input logic [15:0] led, input logic [1:0] ph, input int key, input bit done);
    ent_t e;
    e.led     = led;
    e.ph      = ph;
    e.key     = key;
    e.flick   = 1'b0;
    e.kick_ok = (ph == P_DOWN) && (key < 2) && (led == 16'h0000 || led == 16'h001F);
    e.done    = done;
    seq.push_back(e);
  endtask

  // Ideal per-cycle states after the trigger: all-ones ramps between the per-key bit widths.
  task automatic build(input bit kick0, input bit kick1);
    ent_t e;
    seq.delete();
    push(16'h0000, P_UP, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      int passes;
      int start;
      passes = ((k == 0 && kick0) || (k == 1 && kick1)) ? 2 : 1;
      start  = (k == 0) ? 1 : minw[k-1] + 1;
      for (int p = 0; p < passes; p++) begin
        if (p > 0) begin
          e = seq.pop_back();
          e.flick = 1'b1;
          seq.push_back(e);
          push(ones(minw[k]), P_UP, k, 1'b0);
          start = minw[k] + 1;
        end
        for (int n = start; n <= maxw[k]; n++) push(ones(n), P_UP, k, 1'b0);
        for (int n = maxw[k] - 1; n >= minw[k]; n--) push(ones(n), P_DOWN, k, 1'b0);
      end
    end
    push(16'h0000, P_IDLE, 0, 1'b1);
  endtask

  function automatic int find(input logic [15:0] led, input int key, input logic [1:0] ph);
    for (int i = 0; i < seq.size(); i++)
      if (seq[i].led == led && seq[i].key == key && seq[i].ph == ph) return i;
    return -1;
  endfunction

  // Plays the ideal sequence; at stop_idx either corrupts LED or asserts RST.
  task automatic run(input int stop_idx, input bit stop_rst, input logic [15:0] bad_val);
    int w;
    w = int'($urandom_range(1, 4));
    repeat (w) begin
      LED = 16'h0000; FLICK = 1'b0; tick();
      chk("idle_phase", 16'(PHASE), 16'(P_IDLE));
      chk("idle_exp", EXP_LED, 16'h0000);
    end
    LED = 16'h0000; FLICK = 1'b1; tick();
    for (int i = 0; i < seq.size(); i++) begin
      chk("seq_exp", EXP_LED, seq[i].led);
      chk("seq_phase", 16'(PHASE), 16'(seq[i].ph));
      chk("seq_mismatch", 16'(MISMATCH), 16'h0000);
      chk("seq_err", 16'(ERR), 16'(err_m));
      chk("seq_done", 16'(SEQ_DONE), 16'(seq[i].done));
      if (i == stop_idx && stop_rst) begin
        RST = 1'b1; FLICK = 1'b1; LED = 16'($urandom_range(1, 16'hFFFF)); tick();
        RST = 1'b0; FLICK = 1'b0; LED = 16'h0000;
        err_m = 1'b0; cnt_m = 0;
        chk("rst_phase", 16'(PHASE), 16'(P_IDLE));
        chk("rst_exp", EXP_LED, 16'h0000);
        chk("rst_err", 16'(ERR), 16'h0000);
        chk("rst_cnt", 16'(ERR_CNT), 16'h0000);
        chk("rst_mismatch", 16'(MISMATCH), 16'h0000);
        chk("rst_done", 16'(SEQ_DONE), 16'h0000);
        return;
      end else if (i == stop_idx) begin
        LED = bad_val; FLICK = 1'b0; tick();
        err_m = 1'b1; if (cnt_m < 255) cnt_m++;
        chk("bad_mismatch", 16'(MISMATCH), 16'h0001);
        chk("bad_err", 16'(ERR), 16'h0001);
        chk("bad_phase", 16'(PHASE), 16'(P_RESYNC));
        chk("bad_exp", EXP_LED, 16'h0000);
        chk("bad_cnt", 16'(ERR_CNT), 16'(cnt_exp()));
        w = int'($urandom_range(1, 3));
        repeat (w) begin
          LED = 16'($urandom_range(1, 16'hFFFF)); FLICK = 1'($urandom_range(0, 1)); tick();
          chk("resync_phase", 16'(PHASE), 16'(P_RESYNC));
          chk("resync_pulse", 16'(MISMATCH), 16'h0000);
        end
        LED = 16'h0000; FLICK = 1'b0; tick();
        chk("resync_exit", 16'(PHASE), 16'(P_IDLE));
        chk("resync_exp", EXP_LED, 16'h0000);
        return;
      end else if (i < seq.size() - 1) begin
        LED = seq[i].led;
        FLICK = seq[i].flick
             || (!seq[i].kick_ok && $urandom_range(0, 3) == 0)
             || (seq[i].ph == P_UP && seq[i].led == 16'h00FF)
             || (seq[i].ph == P_DOWN && seq[i].key == 2 && seq[i].led == 16'h0000);
        tick();
      end
    end
    FLICK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    RST = 1'b1; FLICK = 1'($urandom_range(0, 1)); LED = 16'($urandom);
    tick(); tick();
    chk("reset_phase", 16'(PHASE), 16'(P_IDLE));
    chk("reset_exp", EXP_LED, 16'h0000);
    chk("reset_mismatch", 16'(MISMATCH), 16'h0000);
    chk("reset_err", 16'(ERR), 16'h0000);
    chk("reset_done", 16'(SEQ_DONE), 16'h0000);
    chk("reset_cnt", 16'(ERR_CNT), 16'h0000);
    RST = 1'b0; FLICK = 1'b0; LED = 16'h0000;

    build(1'b0, 1'b0); run(-1, 1'b0, 16'h0000);
    build(1'b1, 1'b0); run(-1, 1'b0, 16'h0000);
    build(1'b0, 1'b1); run(-1, 1'b0, 16'h0000);

    build(1'b0, 1'b0);
    run(find(16'h01FF, 0, P_UP), 1'b0, 16'h00FF);

    build(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idx = int'($urandom_range(0, seq.size() - 2));
    run(idx, 1'b0, seq[idx].led ^ 16'($urandom_range(1, 16'hFFFF)));

    build(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run(-1, 1'b0, 16'h0000);

    repeat (300) begin
      LED = 16'($urandom_range(1, 16'hFFFF)); FLICK = 1'($urandom_range(0, 1)); tick();
      if (cnt_m < 255) cnt_m++;
      chk("burst_mismatch", 16'(MISMATCH), 16'h0001);
      chk("burst_phase", 16'(PHASE), 16'(P_RESYNC));
      LED = 16'h0000; FLICK = 1'b0; tick();
      chk("burst_exit", 16'(PHASE), 16'(P_IDLE));
    end
    chk("burst_cnt", 16'(ERR_CNT), 16'(cnt_exp()));
    chk("burst_err", 16'(ERR), 16'h0001);

    build(1'b0, 1'b0);
    run(find(16'h07FF, 1, P_UP), 1'b1, 16'h0000);

    build(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run(-1, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bound_flash_checker.md
BOUND_FLASH_CHECKER -- requirements
Module: bound_flash_checker

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: RST  in  1  synchronous active-high reset.
REQ-003 SHALL have: FLICK  in  1  flasher trigger, sampled on CLK.
REQ-004 SHALL have: LED  in  16  observed flasher output, sampled on CLK.
REQ-005 SHALL have: EXP_LED  out  16  expected LED for the current sample.
REQ-006 SHALL have: PHASE  out  2  model state: 0 IDLE, 1 UP, 2 DOWN, 3 RESYNC.
REQ-007 SHALL have: MISMATCH  out  1  one-cycle pulse, registered, one cycle after a bad sample.
REQ-008 SHALL have: ERR  out  1  sticky error flag.
REQ-009 SHALL have: SEQ_DONE  out  1  one-cycle pulse when a full sequence completes.
REQ-010 SHALL have: ERR_CNT  out  8  mismatch count.

Function
REQ-011 Model SHALL track a step key 0..2 with bounds: key0 max 0xFFFF / min 0x001F; key1 max 0x07FF / min 0x0000; key2 max 0x003F / min 0x0000.
REQ-012 IDLE: EXP_LED=0x0000; FLICK=1 -> UP with EXP_LED held for that cycle; otherwise stay in IDLE.
REQ-013 UP: when EXP_LED!=max, next EXP_LED=(EXP_LED<<1)|1; when EXP_LED==max, next EXP_LED=EXP_LED>>1 and PHASE->DOWN.
REQ-014 DOWN: when EXP_LED!=min, next EXP_LED=EXP_LED>>1.
REQ-015 DOWN at min with key<2: key+1, next EXP_LED=(EXP_LED<<1)|1, PHASE->UP.
REQ-016 DOWN at min with key==2: next EXP_LED=0, key=0, PHASE->IDLE, SEQ_DONE pulses next cycle.
REQ-017 Kick-back: in DOWN, key<2, EXP_LED==0x0000 or 0x001F, FLICK=1 -> PHASE->UP, key unchanged, EXP_LED held for that cycle. FLICK takes priority over REQ-015.
REQ-018 FLICK SHALL be ignored in UP, in DOWN outside the REQ-017 condition, and in RESYNC.
REQ-019 Each cycle in IDLE/UP/DOWN, sampled LED SHALL be compared with EXP_LED; inequality -> MISMATCH=1 next cycle, ERR set, PHASE->RESYNC, key=0.
REQ-020 RESYNC: EXP_LED=0; no comparison; when LED==0x0000 is sampled -> IDLE the following cycle.
REQ-021 Width rules: shifts confined to 16 bits, bit 15 discarded on left shift, 0 shifted in on right shift; no wrap beyond max.
REQ-022 Total checker latency from bad sample to MISMATCH SHALL be exactly 1 cycle; back-to-back bad samples before RESYNC is entered produce only one pulse.

Reset
REQ-023 RST=1 at a rising edge SHALL force PHASE=IDLE, key=0, EXP_LED=0, MISMATCH=0, ERR=0, SEQ_DONE=0, ERR_CNT=0.
REQ-024 RST mid-sequence SHALL discard all model state, with no MISMATCH or SEQ_DONE produced for that cycle.
REQ-025 RST SHALL take priority over FLICK and comparison in the same cycle.

Configuration
REQ-026 Macro BFC_ERR_CNT_EN defined: ERR_CNT increments on each MISMATCH pulse and saturates at 0xFF.
REQ-027 BFC_ERR_CNT_EN undefined: no counter logic is built and ERR_CNT is constant 0; all other behaviour is identical.

Structure
REQ-028 Package bfc_pkg SHALL hold the phase enum (IDLE/UP/DOWN/RESYNC), the kick-back constants 0x0000/0x001F, MAX_KEY=3, and the per-key max/min bound table.
REQ-029 Sub-module bfc_next_led SHALL be purely combinational: given phase, key, EXP_LED and FLICK, it outputs next phase, next key and next EXP_LED. The top level holds registers, compare and counter.

Verification
REQ-030 FLICK pulse in IDLE, then LED driven by an ideal model through 0x0001..0xFFFF..0x001F..0x07FF..0x0000..0x003F..0x0000 -> no MISMATCH, ERR=0, one SEQ_DONE.
REQ-031 Ideal run with LED=0x00FF forced at the expected 0x01FF step -> MISMATCH one cycle later, ERR=1, PHASE=3; LED=0 -> PHASE=0 next cycle.
REQ-032 FLICK while DOWN at 0x001F in key0 -> PHASE=UP, EXP_LED stays 0x001F one cycle, then 0x003F; ideal LED gives no error.
REQ-033 FLICK during UP at 0x00FF and during key2 DOWN at 0x0000 -> ignored; key2 completes to IDLE with SEQ_DONE.
REQ-034 Force 300 mismatches with BFC_ERR_CNT_EN defined -> ERR_CNT=0xFF; undefined -> ERR_CNT=0.
REQ-035 RST asserted at EXP_LED=0x07FF -> next cycle PHASE=0, EXP_LED=0, ERR=0, ERR_CNT=0, no pulses.
